brr_encoder: RTL and testbench
==============================

BRR_ENCODER -- requirements
Module: brr_encoder

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state updates on rising edge.
REQ-002 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port in_valid, input, 1 bit: sample present on in_pcm.
REQ-004 SHALL have port in_ready, output, 1 bit: encoder accepts a sample this cycle.
REQ-005 SHALL have port in_pcm, input, 15 bits: signed 15-bit PCM sample in the DSP internal format.
REQ-006 SHALL have port cfg_filter, input, 2 bits: BRR filter 0-3 for the block.
REQ-007 SHALL have port cfg_loop, input, 1 bit: header loop flag.
REQ-008 SHALL have port cfg_end, input, 1 bit: header end flag.
REQ-009 SHALL have port hist_clear, input, 1 bit: clear the prediction history.
REQ-010 SHALL have port out_valid, output, 1 bit: out_data holds a valid byte.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accepts the byte.
REQ-012 SHALL have port out_data, output, 8 bits: BRR block byte.
REQ-013 SHALL have port out_last, output, 1 bit: asserted with the 9th byte of a block.
REQ-014 SHALL have port busy, output, 1 bit: high in any state other than LOAD with a zero sample count.

Function
REQ-015 SHALL implement states LOAD, SEARCH, ENCODE and EMIT.
- LOAD->SEARCH after the 16th accepted sample.
- SEARCH->ENCODE after shift 12 has been evaluated.
- ENCODE->EMIT after 16 cycles.
- EMIT->LOAD on the 9th byte handshake.
REQ-016 SHALL drive in_ready=1 only in LOAD and accept a sample on in_valid&in_ready into buffer slot 0..15 in arrival order.
REQ-017 SHALL latch cfg_filter, cfg_loop and cfg_end on acceptance of sample 0; changes after that have no effect on the current block.
REQ-018 SHALL keep history p1 (newest) and p2 as 15-bit reconstructed samples carried across blocks.
REQ-019 SHALL use prediction equal to the decoder filter term on p1/p2:
- filter 0: 0
- filter 1: p1*15/16
- filter 2: p1*61/32 - p2*15/16
- filter 3: p1*115/64 - p2*13/16
- each product truncated toward -inf, exactly as the DSP decode path computes it.
REQ-020 SHALL compute the nibble for each sample and shift s as follows:
- r = in - pred, as 17-bit signed.
- n = (2r) when s=0, else (2r + 2^(s-1)) >>> s.
- clamp n to -8..7.
REQ-021 SHALL reconstruct each sample as ((n<<s)>>>1) + pred, wrapped to 15 bits, then shift that value into p1/p2.
REQ-022 SHALL evaluate SEARCH as 13 passes (s=0..12) of 16 cycles each (208 cycles), one sample per cycle:
- each pass starts from the block-entry p1/p2.
- each pass accumulates the sum of |in - recon| in a 21-bit saturating accumulator.
REQ-023 SHALL select the shift with the minimum error sum; on a tie, the lowest shift wins.
REQ-024 SHALL re-run the selected shift in ENCODE (16 cycles), storing nibbles and committing the final p1/p2 to history.
REQ-025 SHALL emit 9 bytes in EMIT:
- byte 0 = {shift[3:0], filter[1:0], loop, end}.
- bytes 1-8 each hold two nibbles, earlier sample in bits 7:4.
REQ-026 SHALL hold out_data, out_last and out_valid stable while out_valid=1 and out_ready=0, advancing the byte index only on out_valid&out_ready.
REQ-027 SHALL assert out_valid in the first EMIT cycle, giving latency from the 16th sample accept to byte 0 valid of 225 cycles.
REQ-028 SHALL zero p1/p2 when hist_clear is sampled high in LOAD with zero samples accepted; in every other state hist_clear SHALL be ignored.
REQ-029 SHALL return to LOAD with zero samples accepted after the last byte, with in_ready=1 in the following cycle.

Reset
REQ-030 SHALL, on reset_n low, asynchronously force:
- state LOAD, sample count 0, byte index 0.
- p1=p2=0, latched cfg=0.
- in_ready=1, out_valid=0, out_last=0, out_data=0x00, busy=0.
REQ-031 SHALL abandon any partial block (samples, search results, pending bytes) on reset and emit nothing from it.

Verification
REQ-032 SHALL pass this scenario: 16 samples of 0x0000, filter 0, end=1, loop=0, out_ready=1 -> bytes 0x01 then 8x 0x00, out_last on byte 9.
REQ-033 SHALL pass this scenario: 16 samples of 0x0008, filter 0, flags 0 -> shift 2 chosen (error 0) -> 0x20 then 8x 0x44; p1=p2=0x0008 afterward.
REQ-034 SHALL pass this scenario: 16 samples of 0x7FFF (-1), filter 0 -> shift 0 -> 0x00 then 8x 0xEE.
REQ-035 SHALL pass this scenario: out_ready low for 5 cycles at byte 3 -> out_data, out_valid and out_last unchanged for those cycles, with no byte dropped or duplicated.
REQ-036 SHALL pass this scenario: reset_n pulsed low during SEARCH and again during EMIT byte 4 -> all outputs at reset values immediately, in_ready=1, no further bytes, and the next block encodes from p1=p2=0.
REQ-037 SHALL pass this scenario: two back-to-back filter-1 blocks with a ramp input -> output bit-exactly matches a reference model, and the decoder fed these bytes reproduces every recon value.

Source files
------------

// File: rtl/brr_encoder.sv
`default_nettype none
// brr_encoder -- 16-sample BRR block encoder with an exhaustive 13-shift error search.
// Rev 1.0
module brr_encoder (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [14:0] in_pcm,
  input  logic [1:0]  cfg_filter,
  input  logic        cfg_loop,
  input  logic        cfg_end,
  input  logic        hist_clear,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_last,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_SEARCH = 2'd1,
    S_ENCODE = 2'd2,
    S_EMIT   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         idx_q, idx_d;
  logic [3:0]         pass_q, pass_d;
  logic [3:0]         byte_q, byte_d;
  logic [1:0]         filt_q;
  logic               loop_q, end_q;
  logic signed [14:0] p1_q, p2_q;
  logic signed [14:0] wp1_q, wp2_q;
  logic [20:0]        acc_q, best_err_q;
  logic [3:0]         best_q;
  logic [14:0]        samp_q [16];
  logic [3:0]         nib_q  [16];

  logic               w_accept;
  logic [3:0]         w_shift;
  logic signed [14:0] w_cur_p1, w_cur_p2;
  logic signed [21:0] w_p1x, w_p2x, w_samp, w_pred;
  logic signed [21:0] w_r2, w_q, w_nx, w_ns, w_diff, w_abs;
  logic [3:0]         w_nib;
  logic signed [14:0] w_rec;
  logic [20:0]        w_err, w_acc_base, w_acc_next;
  logic [21:0]        w_sum;
  logic [2:0]         w_pair;
  logic [7:0]         w_byte;

  // Every pass (and the final encode) restarts from the block-entry history.
  assign w_cur_p1 = (idx_q == 4'd0) ? p1_q : wp1_q;
  assign w_cur_p2 = (idx_q == 4'd0) ? p2_q : wp2_q;
  assign w_shift  = (state_q == S_ENCODE) ? best_q : pass_q;
  assign w_p1x    = {{7{w_cur_p1[14]}}, w_cur_p1};
  assign w_p2x    = {{7{w_cur_p2[14]}}, w_cur_p2};
  assign w_samp   = {{7{samp_q[idx_q][14]}}, samp_q[idx_q]};

  always_comb begin
    w_pred = '0;
    case (filt_q)
      2'd1:    w_pred = (w_p1x * 22'sd15) >>> 4;
      2'd2:    w_pred = ((w_p1x * 22'sd61) >>> 5) - ((w_p2x * 22'sd15) >>> 4);
      2'd3:    w_pred = ((w_p1x * 22'sd115) >>> 6) - ((w_p2x * 22'sd13) >>> 4);
      default: w_pred = '0;
    endcase
  end

  assign w_r2 = (w_samp - w_pred) <<< 1;

  always_comb begin
    w_q = w_r2;
    if (w_shift != 4'd0) w_q = (w_r2 + (22'sd1 <<< (w_shift - 4'd1))) >>> w_shift;
  end

  always_comb begin
    if (w_q > 22'sd7)       w_nib = 4'h7;
    else if (w_q < -22'sd8) w_nib = 4'h8;
    else                    w_nib = w_q[3:0];
  end

  assign w_nx   = {{18{w_nib[3]}}, w_nib};
  assign w_ns   = (w_nx <<< w_shift) >>> 1;
  assign w_rec  = 15'(w_ns + w_pred);
  assign w_diff = w_samp - {{7{w_rec[14]}}, w_rec};
  assign w_abs  = w_diff[21] ? -w_diff : w_diff;
  assign w_err  = 21'(w_abs);

  assign w_acc_base = (idx_q == 4'd0) ? 21'd0 : acc_q;
  assign w_sum      = {1'b0, w_acc_base} + {1'b0, w_err};
  assign w_acc_next = w_sum[21] ? {21{1'b1}} : w_sum[20:0];

  assign w_pair = 3'(byte_q - 4'd1);
  assign w_byte = (byte_q == 4'd0) ? {best_q, filt_q, loop_q, end_q}
                                   : {nib_q[{w_pair, 1'b0}], nib_q[{w_pair, 1'b1}]};

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pass_d    = pass_q;
    byte_d    = byte_q;
    w_accept  = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = 8'h00;
    busy      = 1'b1;
    case (state_q)
      S_LOAD: begin
        in_ready = 1'b1;
        busy     = (idx_q != 4'd0);
        if (in_valid) begin
          w_accept = 1'b1;
          idx_d    = idx_q + 4'd1;
          if (idx_q == 4'd15) begin
            state_d = S_SEARCH;
            pass_d  = 4'd0;
          end
        end
      end
      S_SEARCH: begin
        idx_d = idx_q + 4'd1;
        if (idx_q == 4'd15) begin
          if (pass_q == 4'd12) state_d = S_ENCODE;
          else                 pass_d  = pass_q + 4'd1;
        end
      end
      S_ENCODE: begin
        idx_d = idx_q + 4'd1;
        if (idx_q == 4'd15) begin
          state_d = S_EMIT;
          byte_d  = 4'd0;
        end
      end
      S_EMIT: begin
        out_valid = 1'b1;
        out_last  = (byte_q == 4'd8);
        out_data  = w_byte;
        if (out_ready) begin
          if (byte_q == 4'd8) begin
            state_d = S_LOAD;
            byte_d  = 4'd0;
          end else begin
            byte_d = byte_q + 4'd1;
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_LOAD;
      idx_q      <= 4'd0;
      pass_q     <= 4'd0;
      byte_q     <= 4'd0;
      filt_q     <= 2'd0;
      loop_q     <= 1'b0;
      end_q      <= 1'b0;
      p1_q       <= '0;
      p2_q       <= '0;
      wp1_q      <= '0;
      wp2_q      <= '0;
      acc_q      <= '0;
      best_err_q <= '0;
      best_q     <= 4'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pass_q  <= pass_d;
      byte_q  <= byte_d;
      if (state_q == S_LOAD && idx_q == 4'd0) begin
        if (hist_clear) begin
          p1_q <= '0;
          p2_q <= '0;
        end
        if (in_valid) begin
          filt_q <= cfg_filter;
          loop_q <= cfg_loop;
          end_q  <= cfg_end;
        end
      end
      if (state_q == S_SEARCH || state_q == S_ENCODE) begin
        wp1_q <= w_rec;
        wp2_q <= w_cur_p1;
      end
      if (state_q == S_SEARCH) begin
        acc_q <= w_acc_next;
        // Strict less-than keeps the lowest shift on a tie.
        if (idx_q == 4'd15 && (pass_q == 4'd0 || w_acc_next < best_err_q)) begin
          best_err_q <= w_acc_next;
          best_q     <= pass_q;
        end
      end
      if (state_q == S_ENCODE && idx_q == 4'd15) begin
        p1_q <= w_rec;
        p2_q <= w_cur_p1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) samp_q[idx_q] <= in_pcm;
    if (state_q == S_ENCODE) nib_q[idx_q] <= w_nib;
  end

endmodule
`default_nettype wire

// File: tb/tb_brr_encoder.sv
`default_nettype none
// tb_brr_encoder -- scoreboard bench for brr_encoder with an independent encoder/decoder model.
// Rev 1.0
module tb_brr_encoder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [14:0] in_pcm;
  logic [1:0]  cfg_filter;
  logic        cfg_loop;
  logic        cfg_end;
  logic        hist_clear;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic        busy;

  always #5 clk = ~clk;

  brr_encoder dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pcm     (in_pcm),
    .cfg_filter (cfg_filter),
    .cfg_loop   (cfg_loop),
    .cfg_end    (cfg_end),
    .hist_clear (hist_clear),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_q [$];
  int         rec_q [$];
  int         m_p1 = 0;
  int         m_p2 = 0;

  function automatic int fdiv(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  function automatic int wrap15(input int x);
    int v;
    v = x & 32'h7FFF;
    if (v >= 16384) v = v - 32768;
    return v;
  endfunction

  function automatic int predict(input int f, input int p1, input int p2);
    case (f)
      1:       return fdiv(p1 * 15, 16);
      2:       return fdiv(p1 * 61, 32) - fdiv(p2 * 15, 16);
      3:       return fdiv(p1 * 115, 64) - fdiv(p2 * 13, 16);
      default: return 0;
    endcase
  endfunction

  function automatic int quant(input int r, input int s);
    int t;
    t = 2 * r;
    if (s > 0) t = fdiv(t + (1 << (s - 1)), 1 << s);
    if (t > 7) t = 7;
    if (t < -8) t = -8;
    return t;
  endfunction

  function automatic int decode(input int n, input int s, input int pr);
    return wrap15(fdiv(n * (1 << s), 2) + pr);
  endfunction

  function automatic void model_block(input logic [14:0] smp [16], input int f,
                                      input bit lp, input bit en, input int clr_idx);
    int x [16];
    int nb [16];
    int best, best_err, err, p1, p2, pr, n, rc;
    logic [7:0] b0;
    if (clr_idx == 0) begin m_p1 = 0; m_p2 = 0; end
    for (int i = 0; i < 16; i++) begin
      x[i] = int'(smp[i]);
      if (x[i] >= 16384) x[i] = x[i] - 32768;
    end
    best = -1;
    best_err = 0;
    for (int s = 0; s <= 12; s++) begin
      p1 = m_p1; p2 = m_p2; err = 0;
      for (int i = 0; i < 16; i++) begin
        pr = predict(f, p1, p2);
        n  = quant(x[i] - pr, s);
        rc = decode(n, s, pr);
        err += (x[i] > rc) ? (x[i] - rc) : (rc - x[i]);
        p2 = p1; p1 = rc;
      end
      if (best < 0 || err < best_err) begin best = s; best_err = err; end
    end
    p1 = m_p1; p2 = m_p2;
    for (int i = 0; i < 16; i++) begin
      pr = predict(f, p1, p2);
      n  = quant(x[i] - pr, best);
      rc = decode(n, best, pr);
      nb[i] = n;
      rec_q.push_back(rc);
      p2 = p1; p1 = rc;
    end
    m_p1 = p1; m_p2 = p2;
    b0 = {4'(best), 2'(f), lp, en};
    exp_q.push_back(b0);
    for (int k = 0; k < 8; k++) exp_q.push_back({4'(nb[2*k]), 4'(nb[2*k+1])});
  endfunction

  task automatic send_sample(input logic [14:0] d, input bit clr, output bit ok);
    int t = 0;
    in_valid = 1'b1; in_pcm = d; hist_clear = clr;
    while (!in_ready && t < 3000) begin @(negedge clk); t++; end
    ok = in_ready;
    @(negedge clk);
    in_valid = 1'b0; hist_clear = 1'b0;
  endtask

  // Config flags are inverted after sample 0 so late changes must not leak into the block.
  task automatic send_block(input logic [14:0] smp [16], input int f, input bit lp,
                            input bit en, input int clr_idx, output bit ok);
    bit sok;
    ok = 1'b1;
    model_block(smp, f, lp, en, clr_idx);
    cfg_filter = 2'(f); cfg_loop = lp; cfg_end = en;
    for (int i = 0; i < 16; i++) begin
      send_sample(smp[i], (i == clr_idx), sok);
      if (!sok) ok = 1'b0;
      if (i == 0) begin cfg_filter = ~cfg_filter; cfg_loop = ~lp; cfg_end = ~en; end
    end
  endtask

  task automatic collect_block(output logic [71:0] b, output logic [8:0] lst, output bit to);
    int got = 0;
    int t = 0;
    b = '0; lst = '0;
    while (got < 9 && t < 3000) begin
      if (out_valid && out_ready) begin
        b[8*got +: 8] = out_data; lst[got] = out_last; got++;
      end
      @(negedge clk); t++;
    end
    to = (got < 9);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; in_pcm = '0; cfg_filter = '0; cfg_loop = 1'b0;
    cfg_end = 1'b0; hist_clear = 1'b0; out_ready = 1'b1;
    #1;
    n_tests++;
    if ({in_ready, out_valid, out_last, out_data, busy} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b last=%b data=%02h busy=%b, want 1 0 0 00 0",
               in_ready, out_valid, out_last, out_data, busy);
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_release: got rdy=%b vld=%b busy=%b, want 1 0 0", in_ready, out_valid, busy);
    end
  endtask

  task automatic test_zero_block();
    logic [14:0] s [16];
    logic [71:0] b; logic [8:0] l; logic [7:0] e;
    bit ok, to; int cnt;
    for (int i = 0; i < 16; i++) s[i] = 15'h0000;
    send_block(s, 0, 1'b0, 1'b1, 0, ok);
    n_tests++;
    if (!ok || busy !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_busy: got ok=%b busy=%b rdy=%b, want 1 1 0", ok, busy, in_ready);
    end
    cnt = 0;
    while (!out_valid && cnt < 400) begin @(negedge clk); cnt++; end
    // cnt counts edges after the accepting edge, so the accept cycle adds one.
    n_tests++;
    if (cnt + 1 != 225) begin
      n_fail++;
      $display("FAIL zero_latency: got %0d cycles, want 225", cnt + 1);
    end
    collect_block(b, l, to);
    for (int k = 0; k < 9; k++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
      n_tests++;
      if (to || b[8*k +: 8] !== e || l[k] !== (k == 8)) begin
        n_fail++;
        $display("FAIL zero_byte%0d: got %02h last=%b to=%b, want %02h last=%b", k, b[8*k +: 8], l[k], to, e, (k == 8));
      end
    end
    n_tests++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_return_load: got rdy=%b busy=%b vld=%b, want 1 0 0", in_ready, busy, out_valid);
    end
  endtask

  task automatic test_const8();
    logic [14:0] s [16];
    logic [71:0] b; logic [8:0] l; logic [7:0] e;
    bit ok, to;
    for (int i = 0; i < 16; i++) s[i] = 15'h0008;
    send_block(s, 0, 1'b0, 1'b0, -1, ok);
    collect_block(b, l, to);
    for (int k = 0; k < 9; k++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
      n_tests++;
      if (!ok || to || b[8*k +: 8] !== e || l[k] !== (k == 8)) begin
        n_fail++;
        $display("FAIL const8_byte%0d: got %02h last=%b, want %02h last=%b", k, b[8*k +: 8], l[k], e, (k == 8));
      end
    end
    n_tests++;
    if (dut.p1_q !== 15'sd8 || dut.p2_q !== 15'sd8) begin
      n_fail++;
      $display("FAIL const8_history: got p1=%0d p2=%0d, want 8 8", dut.p1_q, dut.p2_q);
    end
  endtask

  task automatic test_neg1();
    logic [14:0] s [16];
    logic [71:0] b; logic [8:0] l; logic [7:0] e;
    bit ok, to;
    for (int i = 0; i < 16; i++) s[i] = 15'h7FFF;
    send_block(s, 0, 1'b0, 1'b0, -1, ok);
    collect_block(b, l, to);
    for (int k = 0; k < 9; k++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
      n_tests++;
      if (!ok || to || b[8*k +: 8] !== e || l[k] !== (k == 8)) begin
        n_fail++;
        $display("FAIL neg1_byte%0d: got %02h last=%b, want %02h last=%b", k, b[8*k +: 8], l[k], e, (k == 8));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [14:0] s [16];
    logic [71:0] b; logic [8:0] l; logic [7:0] e, hd;
    logic hl;
    bit ok, held;
    int got, t;
    for (int i = 0; i < 16; i++) s[i] = 15'(1000 + 450 * i);
    send_block(s, 2, 1'b1, 1'b0, -1, ok);
    got = 0; t = 0; held = 1'b0; b = '0; l = '0;
    while (got < 9 && t < 3000) begin
      if (out_valid) begin
        if (got == 3 && !held) begin
          held = 1'b1; out_ready = 1'b0; hd = out_data; hl = out_last;
          for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_tests++;
            if ({out_valid, out_data, out_last} !== {1'b1, hd, hl}) begin
              n_fail++;
              $display("FAIL bp_hold%0d: got vld=%b data=%02h last=%b, want 1 %02h %b", c, out_valid, out_data, out_last, hd, hl);
            end
          end
          out_ready = 1'b1;
        end
        b[8*got +: 8] = out_data; l[got] = out_last; got++;
      end
      @(negedge clk); t++;
    end
    for (int k = 0; k < 9; k++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
      n_tests++;
      if (!ok || got < 9 || b[8*k +: 8] !== e || l[k] !== (k == 8)) begin
        n_fail++;
        $display("FAIL bp_byte%0d: got %02h last=%b, want %02h last=%b", k, b[8*k +: 8], l[k], e, (k == 8));
      end
    end
  endtask

  task automatic test_hist_clear();
    logic [14:0] s [16];
    logic [71:0] b; logic [8:0] l; logic [7:0] e;
    bit ok, to;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 16; i++) s[i] = 15'(20000 + 37 * i * (pass + 1));
      // Pass 0 raises hist_clear mid-load (ignored); pass 1 raises it with sample 0.
      send_block(s, (pass == 0) ? 3 : 1, 1'b0, 1'b1, (pass == 0) ? 5 : 0, ok);
      collect_block(b, l, to);
      for (int k = 0; k < 9; k++) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
        n_tests++;
        if (!ok || to || b[8*k +: 8] !== e || l[k] !== (k == 8)) begin
          n_fail++;
          $display("FAIL hclr%0d_byte%0d: got %02h last=%b, want %02h last=%b", pass, k, b[8*k +: 8], l[k], e, (k == 8));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [14:0] s [16];
    logic [71:0] b; logic [8:0] l; logic [7:0] e;
    bit ok, to;
    int got, t, stray;
    for (int i = 0; i < 16; i++) s[i] = 15'(3000 + 200 * i);
    send_block(s, 1, 1'b0, 1'b0, -1, ok);
    repeat (50) @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_tests++;
    if ({in_ready, out_valid, out_last, out_data, busy} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL rst_search: got rdy=%b vld=%b last=%b data=%02h busy=%b, want 1 0 0 00 0", in_ready, out_valid, out_last, out_data, busy);
    end
    @(negedge clk);
    reset_n = 1'b1;
    exp_q.delete(); rec_q.delete(); m_p1 = 0; m_p2 = 0;

    send_block(s, 1, 1'b0, 1'b0, -1, ok);
    got = 0; t = 0;
    while (got < 4 && t < 3000) begin
      if (out_valid) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
        n_tests++;
        if (out_data !== e) begin
          n_fail++;
          $display("FAIL rst_pre_byte%0d: got %02h, want %02h", got, out_data, e);
        end
        got++;
      end
      @(negedge clk); t++;
    end
    reset_n = 1'b0;
    #1;
    n_tests++;
    if ({in_ready, out_valid, out_last, out_data, busy} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL rst_emit: got rdy=%b vld=%b last=%b data=%02h busy=%b, want 1 0 0 00 0", in_ready, out_valid, out_last, out_data, busy);
    end
    @(negedge clk);
    reset_n = 1'b1;
    exp_q.delete(); rec_q.delete(); m_p1 = 0; m_p2 = 0;
    stray = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (out_valid) stray++;
    end
    n_tests++;
    if (stray != 0) begin
      n_fail++;
      $display("FAIL rst_no_bytes: got %0d valid cycles, want 0", stray);
    end

    for (int i = 0; i < 16; i++) s[i] = 15'(8000 + 100 * i);
    send_block(s, 1, 1'b0, 1'b0, -1, ok);
    collect_block(b, l, to);
    for (int k = 0; k < 9; k++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
      n_tests++;
      if (!ok || to || b[8*k +: 8] !== e || l[k] !== (k == 8)) begin
        n_fail++;
        $display("FAIL rst_post_byte%0d: got %02h last=%b, want %02h last=%b", k, b[8*k +: 8], l[k], e, (k == 8));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [14:0] s1 [16];
    logic [14:0] s2 [16];
    logic [71:0] b [2];
    logic [8:0]  l [2];
    logic [7:0]  e, by;
    bit ok1, ok2, to1, to2;
    int d_p1, d_p2, sh, f, n, pr, rc, want;
    logic [3:0] nb;
    for (int i = 0; i < 16; i++) begin
      s1[i] = 15'(100 + 300 * i);
      s2[i] = 15'(4900 - 250 * i);
    end
    exp_q.delete(); rec_q.delete();
    fork
      begin
        send_block(s1, 1, 1'b1, 1'b0, 0, ok1);
        send_block(s2, 1, 1'b0, 1'b1, -1, ok2);
      end
      begin
        collect_block(b[0], l[0], to1);
        collect_block(b[1], l[1], to2);
      end
    join
    for (int blk = 0; blk < 2; blk++) begin
      for (int k = 0; k < 9; k++) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
        n_tests++;
        if (!ok1 || !ok2 || to1 || to2 || b[blk][8*k +: 8] !== e || l[blk][k] !== (k == 8)) begin
          n_fail++;
          $display("FAIL b2b%0d_byte%0d: got %02h last=%b, want %02h last=%b", blk, k, b[blk][8*k +: 8], l[blk][k], e, (k == 8));
        end
      end
    end
    d_p1 = 0; d_p2 = 0;
    for (int blk = 0; blk < 2; blk++) begin
      by = b[blk][7:0];
      sh = int'(by[7:4]);
      f  = int'(by[3:2]);
      for (int k = 0; k < 16; k++) begin
        by = b[blk][8*(1 + k/2) +: 8];
        nb = (k % 2 == 0) ? by[7:4] : by[3:0];
        n  = int'(nb);
        if (n >= 8) n = n - 16;
        pr = predict(f, d_p1, d_p2);
        rc = decode(n, sh, pr);
        want = (rec_q.size() > 0) ? rec_q.pop_front() : 99999;
        n_tests++;
        if (rc !== want) begin
          n_fail++;
          $display("FAIL b2b_decode blk%0d s%0d: got recon %0d, want %0d", blk, k, rc, want);
        end
        d_p2 = d_p1; d_p1 = rc;
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero_block();
    test_const8();
    test_neg1();
    test_backpressure();
    test_hist_clear();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end

endmodule
`default_nettype wire
